// File: rtl/quire_norm_pipe.sv
// quire_norm_pipe: carry-propagates a segmented carry-save quire accumulator and normalises it
// into sign, signed scale factor, rounded mantissa fraction and ovf/udf/zero flags.
// Latency 3 cycles, throughput 1/cycle; all stages advance together whenever the output register
// is empty or being consumed, so in_ready only drops while a result is held for the consumer.
//
// Ports:
//   clk_i, rstn          clock, async active-low reset
//   flush                synchronous clear of every in-flight transaction
//   in_valid/in_ready    input handshake; rnd_mode, acc_head, acc_seg sampled on transfer
//   acc_head             two's-complement head segment (HEADW bits)
//   acc_seg              NSEG packed segments of SEGW payload + 2 carry bits, segment 0 at the LSBs
//   out_valid/out_ready  output handshake
//   sign_q, sf_q, mts_q  result sign, signed scale factor, mantissa fraction (no hidden bit)
//   ovf, udf, zero       range / exact-zero flags
module quire_norm_pipe #(
  parameter int NSEG    = 4,
  parameter int SEGW    = 24,
  parameter int HEADW   = 6,
  parameter int FRACSEG = 2,
  parameter int MTSW    = 8,
  parameter int SF_MAX  = 40,
  parameter int SF_MIN  = -40,
  parameter int SFW     = $clog2(HEADW + NSEG * SEGW) + 2
) (
  input  logic                       clk_i,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       rnd_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [HEADW-1:0]           acc_head,
  input  logic [NSEG*(SEGW+2)-1:0]   acc_seg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       sign_q,
  output logic [SFW-1:0]             sf_q,
  output logic [MTSW-1:0]            mts_q,
  output logic                       ovf,
  output logic                       udf,
  output logic                       zero
);

  localparam int W  = HEADW + NSEG * SEGW;
  localparam int SW = SEGW + 2;
  localparam int BP = FRACSEG * SEGW;
  localparam int PW = $clog2(W);
  localparam logic signed [SFW-1:0] SF_MAX_S = SFW'(SF_MAX);
  localparam logic signed [SFW-1:0] SF_MIN_S = SFW'(SF_MIN);

  logic advance;

  // stage 1 registers
  logic         s1_vld_q, s1_vld_d, s1_sign_q, s1_sign_d, s1_mneg_q, s1_mneg_d, s1_rnd_q, s1_rnd_d;
  logic [W-1:0] s1_mag_q, s1_mag_d;
  logic [W-1:0] acc_sum;

  // stage 2 registers
  logic                  s2_vld_q, s2_vld_d, s2_sign_q, s2_sign_d, s2_mneg_q, s2_mneg_d;
  logic                  s2_rnd_q, s2_rnd_d, s2_zero_q, s2_zero_d, s2_sticky_q, s2_sticky_d;
  logic [MTSW:0]         s2_top_q, s2_top_d;
  logic signed [SFW-1:0] s2_sf_q, s2_sf_d;
  logic [PW-1:0]         lead_pos;
  logic [W-1:0]          norm;

  // stage 3 / output registers
  logic                  out_valid_q, out_valid_d, sign_d, ovf_q, ovf_d, udf_q, udf_d, zero_q, zero_d;
  logic [SFW-1:0]        sf_d;
  logic [MTSW-1:0]       mts_d;
  logic [MTSW-1:0]       mts_raw, mts_rnd;
  logic                  guard_bit, inc, wrap;
  logic signed [SFW-1:0] sf_rnd;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign zero      = zero_q;

  // Stage 1: the ripple of carry fields into the next segment is equivalent to summing every
  // segment (payload + carries) at its own weight; head carry-out falls off the top (mod 2^W).
  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < NSEG; i++) begin
      acc_sum = acc_sum + (W'(acc_seg[i*SW +: SW]) << (i * SEGW));
    end
    acc_sum = acc_sum + (W'(acc_head) << (NSEG * SEGW));

    s1_sign_d = acc_sum[W-1];
    s1_mag_d  = acc_sum[W-1] ? (~acc_sum + W'(1)) : acc_sum;
    // only the most-negative value still has its top bit set after negation
    s1_mneg_d = acc_sum[W-1] && s1_mag_d[W-1];
    s1_rnd_d  = rnd_mode;
    if (!advance) begin
      s1_sign_d = s1_sign_q;
      s1_mag_d  = s1_mag_q;
      s1_mneg_d = s1_mneg_q;
      s1_rnd_d  = s1_rnd_q;
    end
    s1_vld_d = flush ? 1'b0 : (advance ? in_valid : s1_vld_q);
  end

  // Stage 2: leading-one search, then left-justify so the hidden bit lands at W-1.
  // A zero magnitude leaves the hidden bit clear, which doubles as the zero detect.
  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < W; i++) begin
      if (s1_mag_q[i]) lead_pos = PW'(i);
    end
    norm = s1_mag_q << (PW'(W - 1) - lead_pos);

    s2_zero_d   = ~norm[W-1];
    s2_top_d    = norm[W-2 -: MTSW+1];      // mantissa fraction followed by guard bit
    s2_sticky_d = |norm[W-3-MTSW:0];
    s2_sf_d     = s2_zero_d ? '0 : (SFW'(lead_pos) - SFW'(BP));
    s2_sign_d   = s1_sign_q;
    s2_mneg_d   = s1_mneg_q;
    s2_rnd_d    = s1_rnd_q;
    if (!advance) begin
      s2_zero_d   = s2_zero_q;
      s2_top_d    = s2_top_q;
      s2_sticky_d = s2_sticky_q;
      s2_sf_d     = s2_sf_q;
      s2_sign_d   = s2_sign_q;
      s2_mneg_d   = s2_mneg_q;
      s2_rnd_d    = s2_rnd_q;
    end
    s2_vld_d = flush ? 1'b0 : (advance ? s1_vld_q : s2_vld_q);
  end

  // Stage 3: round-nearest-even, renormalise on mantissa wrap, then clamp to range.
  always_comb begin
    mts_raw           = s2_top_q[MTSW:1];
    guard_bit         = s2_top_q[0];
    inc               = s2_rnd_q && guard_bit && (s2_sticky_q || mts_raw[0]);
    {wrap, mts_rnd}   = {1'b0, mts_raw} + {{MTSW{1'b0}}, inc};
    sf_rnd            = s2_sf_q + {{(SFW-1){1'b0}}, wrap};

    out_valid_d = flush ? 1'b0 : (advance ? s2_vld_q : out_valid_q);
    sign_d      = sign_q;
    sf_d        = sf_q;
    mts_d       = mts_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    zero_d      = zero_q;
    if (advance) begin
      sign_d = s2_sign_q;
      sf_d   = sf_rnd;
      mts_d  = mts_rnd;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
      zero_d = 1'b0;
      if (s2_zero_q) begin
        zero_d = 1'b1;
        udf_d  = 1'b1;
        sf_d   = '0;
        mts_d  = '0;
      end else if (s2_mneg_q || (sf_rnd > SF_MAX_S)) begin
        ovf_d  = 1'b1;
        sf_d   = SF_MAX_S;
        mts_d  = '1;
      end else if (sf_rnd < SF_MIN_S) begin
        udf_d  = 1'b1;
        sf_d   = '0;
        mts_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q    <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mneg_q   <= 1'b0;
      s1_rnd_q    <= 1'b0;
      s1_mag_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_mneg_q   <= 1'b0;
      s2_rnd_q    <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_sticky_q <= 1'b0;
      s2_top_q    <= '0;
      s2_sf_q     <= '0;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      sf_q        <= '0;
      mts_q       <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_sign_q   <= s1_sign_d;
      s1_mneg_q   <= s1_mneg_d;
      s1_rnd_q    <= s1_rnd_d;
      s1_mag_q    <= s1_mag_d;
      s2_vld_q    <= s2_vld_d;
      s2_sign_q   <= s2_sign_d;
      s2_mneg_q   <= s2_mneg_d;
      s2_rnd_q    <= s2_rnd_d;
      s2_zero_q   <= s2_zero_d;
      s2_sticky_q <= s2_sticky_d;
      s2_top_q    <= s2_top_d;
      s2_sf_q     <= s2_sf_d;
      out_valid_q <= out_valid_d;
      sign_q      <= sign_d;
      sf_q        <= sf_d;
      mts_q       <= mts_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      zero_q      <= zero_d;
    end
  end

endmodule

// File: tb/tb_quire_norm_pipe.sv
// tb_quire_norm_pipe: directed and randomised stimulus for quire_norm_pipe with a result queue.
// Expected results are queued on input transfer and compared in order when the DUT hands them off.
// Backpressure is exercised by holding out_ready low and by random consumer stalls.
module tb_quire_norm_pipe;

  typedef struct packed {
    logic       sign;
    logic [8:0] sf;
    logic [7:0] mts;
    logic       ovf;
    logic       udf;
    logic       zero;
  } exp_t;

  logic         clk_i     = 1'b0;
  logic         rstn      = 1'b1;
  logic         flush     = 1'b0;
  logic         rnd_mode  = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [5:0]   acc_head  = '0;
  logic [103:0] acc_seg   = '0;
  logic         in_ready, out_valid, sign_q, ovf, udf, zero;
  logic [8:0]   sf_q;
  logic [7:0]   mts_q;

  exp_t  exp_q[$];
  exp_t  mon_e, mon_g;
  int    checks = 0;
  int    errors = 0;
  string cur_test = "none";

  exp_t         bp_e[5];
  logic [103:0] bp_s[5];
  logic [5:0]   bp_h[5];

  quire_norm_pipe dut (
    .clk_i(clk_i), .rstn(rstn), .flush(flush), .rnd_mode(rnd_mode),
    .in_valid(in_valid), .in_ready(in_ready), .acc_head(acc_head), .acc_seg(acc_seg),
    .out_valid(out_valid), .out_ready(out_ready), .sign_q(sign_q), .sf_q(sf_q),
    .mts_q(mts_q), .ovf(ovf), .udf(udf), .zero(zero)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Results are consumed at the posedge following a negedge with out_valid && out_ready.
  always @(negedge clk_i) begin
    if (rstn && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected_output: got a result (sf=%0d mts=%02h), required none pending",
                 cur_test, $signed(sf_q), mts_q);
      end else begin
        mon_e = exp_q.pop_front();
        mon_g = {sign_q, sf_q, mts_q, ovf, udf, zero};
        if (mon_g !== mon_e) begin
          errors++;
          $display("FAIL %s result: got sign=%0b sf=%0d mts=%02h ovf=%0b udf=%0b zero=%0b, required sign=%0b sf=%0d mts=%02h ovf=%0b udf=%0b zero=%0b",
                   cur_test, mon_g.sign, $signed(mon_g.sf), mon_g.mts, mon_g.ovf, mon_g.udf, mon_g.zero,
                   mon_e.sign, $signed(mon_e.sf), mon_e.mts, mon_e.ovf, mon_e.udf, mon_e.zero);
        end
      end
    end
  end

  function automatic exp_t mk(logic s, int sf, logic [7:0] m, logic o, logic u, logic z);
    return {s, 9'(sf), m, o, u, z};
  endfunction

  function automatic logic [103:0] segs(logic [25:0] s3, logic [25:0] s2, logic [25:0] s1, logic [25:0] s0);
    return {s3, s2, s1, s0};
  endfunction

  // Reference: explicit segment-by-segment carry ripple, top-down leading-one search, bitwise extraction.
  function automatic exp_t model(logic [5:0] h, logic [103:0] s, logic r);
    exp_t e;
    logic [101:0] a, m;
    logic [7:0] mts;
    logic sg, mneg, g, st, inc;
    int carry, val, p, sf;
    carry = 0;
    for (int i = 0; i < 4; i++) begin
      val = int'(s[i*26 +: 26]) + carry;
      a[i*24 +: 24] = val[23:0];
      carry = val >>> 24;
    end
    a[101:96] = h + carry[5:0];
    sg   = a[101];
    m    = sg ? (~a + 102'd1) : a;
    mneg = sg && m[101];
    e = '0;
    e.sign = sg;
    if (m == '0) begin
      e.zero = 1'b1;
      e.udf  = 1'b1;
      return e;
    end
    p = -1;
    for (int i = 101; i >= 0; i--) if (p < 0 && m[i]) p = i;
    for (int k = 1; k <= 8; k++) mts[8-k] = (p - k >= 0) ? m[p-k] : 1'b0;
    g  = (p - 9 >= 0) ? m[p-9] : 1'b0;
    st = 1'b0;
    for (int j = 0; j < p - 9; j++) st = st | m[j];
    inc = r && g && (st || mts[0]);
    sf  = p - 48;
    if (inc) begin
      if (mts == 8'hFF) begin
        mts = 8'h00;
        sf  = sf + 1;
      end else begin
        mts = mts + 8'd1;
      end
    end
    if (mneg || sf > 40) begin
      e.ovf = 1'b1; e.sf = 9'd40; e.mts = 8'hFF;
    end else if (sf < -40) begin
      e.udf = 1'b1;
    end else begin
      e.sf = 9'(sf); e.mts = mts;
    end
    return e;
  endfunction

  // Presents one input until accepted; optionally randomises out_ready each cycle.
  task automatic send(input logic [5:0] h, input logic [103:0] s, input logic r, input exp_t e,
                      input logic track, input int stall_pct);
    logic acc;
    int   budget;
    acc_head = h; acc_seg = s; rnd_mode = r; in_valid = 1'b1;
    budget = 0;
    do begin
      if (stall_pct > 0) out_ready = ($urandom_range(0, 99) >= stall_pct);
      #1;
      acc = in_ready;
      @(posedge clk_i); #1;
      budget++;
    end while (!acc && budget < 50);
    if (acc) begin
      if (track) exp_q.push_back(e);
    end else begin
      checks++; errors++;
      $display("FAIL %s send_timeout: in_ready stayed 0 for %0d cycles, required acceptance", cur_test, budget);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    cur_test = "reset";
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({out_valid, sign_q, sf_q, mts_q, ovf, udf, zero} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b sign=%0b sf=%0d mts=%02h ovf=%0b udf=%0b zero=%0b, required all 0",
               out_valid, sign_q, sf_q, mts_q, ovf, udf, zero);
    end
    repeat (3) @(posedge clk_i);
    #1 rstn = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_plus_one;
    int k;
    cur_test = "plus_one";
    out_ready = 1'b1;
    send(6'h0, segs(26'h0, 26'h1, 26'h0, 26'h0), 1'b1, mk(0, 0, 8'h00, 0, 0, 0), 1'b1, 0);
    @(posedge clk_i); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL plus_one_latency_early: got out_valid=%0b after 2 edges, required 0", out_valid);
    end
    @(posedge clk_i); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL plus_one_latency: got out_valid=%0b after 3 edges, required 1", out_valid);
    end
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin @(posedge clk_i); #1; k++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL plus_one_drain: got %0d results missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_carry_negative;
    int k;
    cur_test = "carry_negative";
    out_ready = 1'b1;
    send(6'h0,  segs(26'h0, 26'h0, 26'h1000000, 26'h0), 1'b1, mk(0, 0, 8'h00, 0, 0, 0), 1'b1, 0);
    send(6'h3F, segs(26'hFFFFFF, 26'hFFFFFE, 26'h800000, 26'h0), 1'b1, mk(1, 0, 8'h80, 0, 0, 0), 1'b1, 0);
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin @(posedge clk_i); #1; k++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL carry_negative_drain: got %0d results missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_rounding;
    int k;
    cur_test = "rounding";
    out_ready = 1'b1;
    send(6'h0, segs(26'h0, 26'h1, 26'h018000, 26'h0), 1'b1, mk(0, 0, 8'h02, 0, 0, 0), 1'b1, 0);
    send(6'h0, segs(26'h0, 26'h1, 26'h018000, 26'h0), 1'b0, mk(0, 0, 8'h01, 0, 0, 0), 1'b1, 0);
    send(6'h0, segs(26'h0, 26'h1, 26'h008000, 26'h0), 1'b1, mk(0, 0, 8'h00, 0, 0, 0), 1'b1, 0);
    send(6'h0, segs(26'h0, 26'h1, 26'hFF8000, 26'h0), 1'b1, mk(0, 1, 8'h00, 0, 0, 0), 1'b1, 0);
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin @(posedge clk_i); #1; k++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rounding_drain: got %0d results missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_range;
    int k;
    cur_test = "range";
    out_ready = 1'b1;
    send(6'h0, segs(26'h200000, 26'h0, 26'h0, 26'h0), 1'b1, mk(0, 40, 8'hFF, 1, 0, 0), 1'b1, 0);
    send(6'h0, segs(26'h0, 26'h0, 26'h0, 26'h1),      1'b1, mk(0, 0, 8'h00, 0, 1, 0), 1'b1, 0);
    send(6'h0, segs(26'h0, 26'h0, 26'h0, 26'h0),      1'b1, mk(0, 0, 8'h00, 0, 1, 1), 1'b1, 0);
    send(6'h20, segs(26'h0, 26'h0, 26'h0, 26'h0),     1'b1, mk(1, 40, 8'hFF, 1, 0, 0), 1'b1, 0);
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin @(posedge clk_i); #1; k++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL range_drain: got %0d results missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0]   h;
    logic [103:0] s;
    logic         r;
    int           sel, k;
    cur_test = "back_to_back";
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) s[i*26 +: 26] = 26'($urandom);
      h = 6'($urandom);
      case (sel)
        1: begin h = 6'h0; s[78 +: 26] = 26'($urandom_range(0, 255)); end
        2: begin h = 6'h3F; s[78 +: 26] = 26'hFFFFFF; end
        3: begin
          h = 6'h0; s[78 +: 26] = '0; s[52 +: 26] = '0; s[26 +: 26] = '0;
          s[0 +: 26] = 26'($urandom >> $urandom_range(0, 25));
        end
        default: ;
      endcase
      r = 1'($urandom);
      send(h, s, r, model(h, s, r), 1'b1, 30);
    end
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin @(posedge clk_i); #1; k++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL back_to_back_drain: got %0d results missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    int   idx, k;
    logic acc;
    cur_test = "backpressure";
    bp_h[0] = 6'h0;  bp_s[0] = segs(26'h0, 26'h1, 26'h0, 26'h0);            bp_e[0] = mk(0, 0, 8'h00, 0, 0, 0);
    bp_h[1] = 6'h3F; bp_s[1] = segs(26'hFFFFFF, 26'hFFFFFE, 26'h800000, 26'h0); bp_e[1] = mk(1, 0, 8'h80, 0, 0, 0);
    bp_h[2] = 6'h0;  bp_s[2] = segs(26'h0, 26'h1, 26'h018000, 26'h0);       bp_e[2] = mk(0, 0, 8'h02, 0, 0, 0);
    bp_h[3] = 6'h0;  bp_s[3] = segs(26'h0, 26'h1, 26'hFF8000, 26'h0);       bp_e[3] = mk(0, 1, 8'h00, 0, 0, 0);
    bp_h[4] = 6'h0;  bp_s[4] = segs(26'h200000, 26'h0, 26'h0, 26'h0);       bp_e[4] = mk(0, 40, 8'hFF, 1, 0, 0);
    out_ready = 1'b0;
    rnd_mode  = 1'b1;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      acc_head = bp_h[idx];
      acc_seg  = bp_s[idx];
      #1;
      acc = in_ready;
      @(posedge clk_i); #1;
      if (acc) begin
        exp_q.push_back(bp_e[idx]);
        if (idx < 4) idx++;
      end
    end
    checks++;
    if (exp_q.size() != 3) begin
      errors++; $display("FAIL backpressure_accepted: got %0d, required 3", exp_q.size());
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL backpressure_in_ready: got %0b, required 0", in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (out_valid !== 1'b1 || {sign_q, sf_q, mts_q, ovf, udf, zero} !== exp_q[0]) begin
        errors++;
        $display("FAIL backpressure_hold: got v=%0b sf=%0d mts=%02h, required v=1 sf=%0d mts=%02h",
                 out_valid, $signed(sf_q), mts_q, $signed(exp_q[0].sf), exp_q[0].mts);
      end
      @(posedge clk_i); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin @(posedge clk_i); #1; k++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL backpressure_drain: got %0d results missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_flush;
    int seen, k;
    cur_test = "flush";
    out_ready = 1'b1;
    send(6'h0, segs(26'h0, 26'h5, 26'h0, 26'h0), 1'b1, '0, 1'b0, 0);
    send(6'h0, segs(26'h0, 26'h7, 26'h0, 26'h0), 1'b1, '0, 1'b0, 0);
    // a third input offered during the flush must be dropped too
    flush = 1'b1;
    in_valid = 1'b1;
    acc_seg = segs(26'h0, 26'h9, 26'h0, 26'h0);
    @(posedge clk_i); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_out_valid: got %0b, required 0", out_valid);
    end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) seen++;
      @(posedge clk_i); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL flush_leak: got %0d valid cycles after flush, required 0", seen);
    end
    send(6'h0, segs(26'h0, 26'h1, 26'h0, 26'h0), 1'b1, mk(0, 0, 8'h00, 0, 0, 0), 1'b1, 0);
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin @(posedge clk_i); #1; k++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL flush_recover: got %0d results missing, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_plus_one();
    test_carry_negative();
    test_rounding();
    test_range();
    test_back_to_back();
    test_backpressure();
    test_flush();
    repeat (4) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quire_norm_pipe.md
Name: quire_norm_pipe

Overview:
- Parametrised successor to the single-stage accumulator-to-scale-factor normaliser in the fractional MAC datapath.
- Takes a carry-save segmented accumulator (NSEG body segments plus a signed head), and propagates carries.
- Converts the result to sign-magnitude, finds the leading one, and emits sign, signed scale factor, rounded mantissa and ovf/udf/zero flags.
- 3-stage pipeline with valid/ready backpressure and synchronous flush; sits between the accumulator array and the output encoder.

Parameters:
- NSEG, 4: number of body segments. Segment 0 is the LSB.
- SEGW, 24: body segment payload width. Each segment carries 2 extra carry bits above the payload.
- HEADW, 6: head segment width, two's complement.
- FRACSEG, 2: number of segments below the binary point. Binary point sits at bit BP=FRACSEG*SEGW.
- MTSW, 8: output mantissa fraction bits; the hidden bit is not emitted.
- SF_MAX, 40: largest representable scale factor.
- SF_MIN, -40: smallest representable scale factor.
- SFW, $clog2(HEADW+NSEG*SEGW)+2: signed scale-factor width.

Ports:
- clk_i  in  1  clock
- rstn  in  1  reset
- flush  in  1  synchronous pipeline clear
- rnd_mode  in  1  rounding mode: 0=truncate, 1=round-nearest-even. Sampled with in_valid.
- in_valid  in  1  input transaction valid
- in_ready  out  1  pipeline can accept
- acc_head  in  HEADW  head segment
- acc_seg  in  NSEG*(SEGW+2)  packed segments. Segment i occupies bits [(i+1)*(SEGW+2)-1 : i*(SEGW+2)].
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- sign_q  out  1  result sign
- sf_q  out  SFW  signed scale factor
- mts_q  out  MTSW  mantissa fraction
- ovf  out  1  overflow
- udf  out  1  underflow
- zero  out  1  exact zero

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk_i. On reset all stage valids are 0 and every output register is 0: out_valid, sign_q, sf_q, mts_q, ovf, udf, zero.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - All three stages move together on advance; bubbles propagate.
  - A transfer occurs when in_valid && in_ready. Output is held stable while out_valid && !out_ready.
  - Latency is 3 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- flush clears all stage valids and out_valid on the next edge. It takes priority over advance and any simultaneous input transfer; data registers need not clear.
- Stage 1, carry propagation:
  - Ripple from segment 0 up: seg[i+1] += seg[i][SEGW+1:SEGW]; head += seg[NSEG-1] top 2 bits.
  - Result is a W=HEADW+NSEG*SEGW bit two's-complement value A. Carry out of the head is discarded (wrap modulo 2^W).
  - sign = A[W-1]. mag = sign ? -A : A, in W bits. mag of the most-negative value is treated as ovf.
- Stage 2, normalisation:
  - Leading-one position p of mag; sf = p - BP, signed.
  - mag == 0 forces zero=1, udf=1, sf=0, mts=0.
- Stage 3, mantissa extraction and rounding:
  - mts = MTSW bits immediately below p, zero-filled if p < MTSW.
  - guard = next bit below; sticky = OR of all lower bits.
  - RNE increments when guard && (sticky || mts[0]).
  - If the increment wraps mts to 0, sf = sf+1.
- Range check after rounding:
  - sf > SF_MAX: ovf=1, sf_q=SF_MAX, mts_q all ones.
  - sf < SF_MIN: udf=1, sf_q=0, mts_q=0, zero=0.
  - Otherwise ovf=udf=0. At most one of ovf/udf may be set, except zero implies udf.
- rnd_mode and sign travel with their transaction; changing rnd_mode between inputs never affects in-flight items.

Test Plan:
Defaults apply (BP=48; seg2 holds the integer LSB).
- Plus one: seg2=1, others 0, rnd=1 -> after 3 cycles out_valid=1, sign=0, sf=0, mts=8'h00, all flags 0.
- Carry propagation: seg1 carry field=2'b01, payload 0; seg2=0 -> identical to plus-one result.
- Negative: head=6'h3F, seg2=24'hFFFFFE, seg1=24'h800000, seg0=0 (-1.5) -> sign=1, sf=0, mts=8'h80.
- Rounding, seg2=1 in every case:
  - seg1=24'h018000: RNE gives mts=8'h02; truncate gives 8'h01.
  - seg1=24'h008000 (tie, even): mts=8'h00.
  - seg1=24'hFF8000: mts=8'h00, sf=1.
- Range and zero:
  - seg3=1<<21 (2^45) -> ovf=1, sf=40, mts=8'hFF.
  - seg0=1 (sf=-48) -> udf=1, mts=0.
  - All zero -> zero=1, udf=1.
- Backpressure and flush:
  - out_ready=0 with 5 back-to-back inputs -> exactly 3 accepted, in_ready=0, output stable.
  - Release out_ready -> 3 results in order, no loss or duplication.
  - flush with 2 items in flight -> out_valid=0 next cycle and those items never appear.
